// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the local-history branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CNT_RESET = WNT;

  // Step a 2-bit counter toward the outcome, pinned at SNT/ST.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state of one 2-bit saturating PHT counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] next
);

  assign next = sat_next(cnt, taken);

endmodule

// File: rtl/branch_predictor.sv
// Two-level local-history predictor: PC-hashed BHT selects a history that indexes a
// PHT of 2-bit counters. Lookup is combinational; training comes only from MEM.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_HASH_BITS   = 3,
  parameter int PHT_INDEX_BITS = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  input  logic                      branchM,
  input  logic                      actually_takenM,
  input  logic                      predict_resultM,
  input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
  output logic                      predict_takeF,
  output logic [PC_HASH_BITS-1:0]   pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  output logic [31:0]               branch_count,
  output logic [31:0]               mispredict_count
);

  localparam int BHT_SIZE = 1 << PC_HASH_BITS;
  localparam int PHT_SIZE = 1 << PHT_INDEX_BITS;

  // Flop arrays so reset can clear every entry asynchronously.
  logic [PHT_INDEX_BITS-1:0] bht [BHT_SIZE];
  logic [1:0]                pht [PHT_SIZE];
  logic [1:0]                pht_next;

  logic unused_pc;
  assign unused_pc = ^{pcF[31:PC_HASH_BITS+2], pcF[1:0]};

  assign pc_hashingF   = pcF[PC_HASH_BITS+1:2];
  assign PHT_indexF    = bht[pc_hashingF];
  assign predict_takeF = pht[PHT_indexF][1];

  sat_counter2 u_pht_ctr (
    .cnt   (pht[PHT_indexM]),
    .taken (actually_takenM),
    .next  (pht_next)
  );

  // No bypass: a lookup of the entry being written sees the old value this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= '0;
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CNT_RESET;
    end else if (branchM) begin
      bht[pc_hashingM] <= {bht[pc_hashingM][PHT_INDEX_BITS-2:0], actually_takenM};
      pht[PHT_indexM]  <= pht_next;
    end
  end

  // Perf counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (branchM) begin
      if (branch_count != '1) branch_count <= branch_count + 32'd1;
      if (!predict_resultM && mispredict_count != '1)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  localparam int HB = 3;
  localparam int IB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pcF;
  logic          branchM;
  logic          actually_takenM;
  logic          predict_resultM;
  logic [HB-1:0] pc_hashingM;
  logic [IB-1:0] PHT_indexM;
  logic          predict_takeF;
  logic [HB-1:0] pc_hashingF;
  logic [IB-1:0] PHT_indexF;
  logic [31:0]   branch_count;
  logic [31:0]   mispredict_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_HASH_BITS(HB), .PHT_INDEX_BITS(IB)) dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (pcF),
    .branchM          (branchM),
    .actually_takenM  (actually_takenM),
    .predict_resultM  (predict_resultM),
    .pc_hashingM      (pc_hashingM),
    .PHT_indexM       (PHT_indexM),
    .predict_takeF    (predict_takeF),
    .pc_hashingF      (pc_hashingF),
    .PHT_indexF       (PHT_indexF),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // One resolved branch through a single rising edge; returns at the next negedge.
  task automatic upd(input logic [HB-1:0] h, input logic [IB-1:0] idx,
                     input logic tk, input logic ok);
    branchM = 1'b1; pc_hashingM = h; PHT_indexM = idx;
    actually_takenM = tk; predict_resultM = ok;
    @(posedge clk); @(negedge clk);
    branchM = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    pcF = pc; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; branchM = 1'b0; actually_takenM = 1'b0; predict_resultM = 1'b1;
    pc_hashingM = '0; PHT_indexM = '0; pcF = 32'h0040_0010;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL reset_pred got=%0b exp=0", predict_takeF); end
    checks++; if (pc_hashingF !== 3'b100) begin failures++; $display("FAIL reset_hash got=%0h exp=4", pc_hashingF); end
    checks++; if (PHT_indexF !== 7'd0) begin failures++; $display("FAIL reset_idx got=%0h exp=0", PHT_indexF); end
    checks++; if (branch_count !== 32'd0) begin failures++; $display("FAIL reset_bcnt got=%0d exp=0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin failures++; $display("FAIL reset_mcnt got=%0d exp=0", mispredict_count); end
  endtask

  task automatic test_train_taken();
    // PHT[0]: 01 -> 10 -> 11 -> 11 (sat) -> 10 after a not-taken
    upd(3'd4, 7'd0, 1'b1, 1'b1);
    look(32'h0040_0010);
    checks++; if (PHT_indexF !== 7'b0000001) begin failures++; $display("FAIL bht4_first got=%0h exp=1", PHT_indexF); end
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL pht1_pred got=%0b exp=0", predict_takeF); end
    look(32'h0000_0000);
    checks++; if (predict_takeF !== 1'b1) begin failures++; $display("FAIL pht0_wt got=%0b exp=1", predict_takeF); end
    upd(3'd4, 7'd0, 1'b1, 1'b1);
    upd(3'd4, 7'd0, 1'b1, 1'b1);
    checks++; if (branch_count !== 32'd3) begin failures++; $display("FAIL train_bcnt got=%0d exp=3", branch_count); end
    look(32'h0040_0010);
    checks++; if (PHT_indexF !== 7'b0000111) begin failures++; $display("FAIL bht4_three got=%0h exp=7", PHT_indexF); end
    upd(3'd4, 7'd0, 1'b1, 1'b1);
    upd(3'd4, 7'd0, 1'b0, 1'b1);
    look(32'h0000_0000);
    checks++; if (predict_takeF !== 1'b1) begin failures++; $display("FAIL pht0_sat_up got=%0b exp=1", predict_takeF); end
    look(32'h0040_0010);
    checks++; if (PHT_indexF !== 7'd30) begin failures++; $display("FAIL bht4_shift got=%0h exp=1e", PHT_indexF); end
  endtask

  task automatic test_sat_down();
    // Give BHT[3] history 0000101 using PHT[6] as a scratch counter.
    upd(3'd3, 7'd6, 1'b1, 1'b1);
    upd(3'd3, 7'd6, 1'b0, 1'b1);
    upd(3'd3, 7'd6, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) upd(3'd1, 7'd5, 1'b0, 1'b1);
    look(32'h0000_000C);
    checks++; if (PHT_indexF !== 7'd5) begin failures++; $display("FAIL hist5_idx got=%0h exp=5", PHT_indexF); end
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL pht5_sat_pred got=%0b exp=0", predict_takeF); end
    // From 00 one taken gives 01, still not-taken.
    upd(3'd1, 7'd5, 1'b1, 1'b1);
    look(32'h0000_000C);
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL pht5_sat_down got=%0b exp=0", predict_takeF); end
    checks++; if (branch_count !== 32'd13) begin failures++; $display("FAIL sat_bcnt got=%0d exp=13", branch_count); end
  endtask

  task automatic test_back_to_back();
    // Hash 2: BHT[2]=0, PHT[0]=10. Write BHT[2] with taken (PHT[2] trained).
    look(32'h0000_0008);
    branchM = 1'b1; pc_hashingM = 3'd2; PHT_indexM = 7'd2;
    actually_takenM = 1'b1; predict_resultM = 1'b1; #1;
    checks++; if (PHT_indexF !== 7'd0) begin failures++; $display("FAIL haz_bht_old got=%0h exp=0", PHT_indexF); end
    checks++; if (predict_takeF !== 1'b1) begin failures++; $display("FAIL haz_bht_old_pred got=%0b exp=1", predict_takeF); end
    @(posedge clk); #1;
    branchM = 1'b0;
    checks++; if (PHT_indexF !== 7'd1) begin failures++; $display("FAIL haz_bht_new got=%0h exp=1", PHT_indexF); end
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL haz_bht_new_pred got=%0b exp=0", predict_takeF); end
    @(negedge clk);
    // Same-cycle write of the PHT entry currently being read (PHT[1]: 01 -> 10).
    branchM = 1'b1; pc_hashingM = 3'd5; PHT_indexM = 7'd1;
    actually_takenM = 1'b1; predict_resultM = 1'b1; #1;
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL haz_pht_old got=%0b exp=0", predict_takeF); end
    @(posedge clk); #1;
    branchM = 1'b0;
    checks++; if (predict_takeF !== 1'b1) begin failures++; $display("FAIL haz_pht_new got=%0b exp=1", predict_takeF); end
    @(negedge clk);
  endtask

  task automatic test_mispredict();
    rst = 1'b1; @(negedge clk); rst = 1'b0; #1;
    for (int i = 1; i <= 10; i++) begin
      upd(3'd6, 7'd9, 1'b1, (i % 3) != 0);
      // Idle cycle that would corrupt BHT[0] and the counters if not gated.
      branchM = 1'b0; pc_hashingM = 3'd0; PHT_indexM = 7'd0;
      actually_takenM = 1'b1; predict_resultM = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (branch_count !== 32'd10) begin failures++; $display("FAIL mis_bcnt got=%0d exp=10", branch_count); end
    checks++; if (mispredict_count !== 32'd3) begin failures++; $display("FAIL mis_mcnt got=%0d exp=3", mispredict_count); end
    look(32'h0000_0000);
    checks++; if (PHT_indexF !== 7'd0) begin failures++; $display("FAIL idle_bht0 got=%0h exp=0", PHT_indexF); end
    look(32'h0000_0018);
    checks++; if (PHT_indexF !== 7'h7F) begin failures++; $display("FAIL bht6_hist got=%0h exp=7f", PHT_indexF); end
  endtask

  task automatic test_async_reset();
    look(32'h0000_0018);
    branchM = 1'b1; pc_hashingM = 3'd6; PHT_indexM = 7'd0; actually_takenM = 1'b1;
    #2 rst = 1'b1; #1;
    checks++; if (PHT_indexF !== 7'd0) begin failures++; $display("FAIL arst_idx got=%0h exp=0", PHT_indexF); end
    checks++; if (predict_takeF !== 1'b0) begin failures++; $display("FAIL arst_pred got=%0b exp=0", predict_takeF); end
    checks++; if (branch_count !== 32'd0) begin failures++; $display("FAIL arst_bcnt got=%0d exp=0", branch_count); end
    checks++; if (mispredict_count !== 32'd0) begin failures++; $display("FAIL arst_mcnt got=%0d exp=0", mispredict_count); end
    // A pending update held across an edge under reset must not land.
    @(posedge clk); #1;
    checks++; if (PHT_indexF !== 7'd0) begin failures++; $display("FAIL arst_hold_idx got=%0h exp=0", PHT_indexF); end
    checks++; if (branch_count !== 32'd0) begin failures++; $display("FAIL arst_hold_bcnt got=%0d exp=0", branch_count); end
    @(negedge clk);
    branchM = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_sat_down();
    test_back_to_back();
    test_mispredict();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
